// File: rtl/uart_rx_framer.sv
// UART receive framer: turns recovered line-bit strobes into bytes with frame/overrun checks.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_framer #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bit_i,
    input  logic                 bit_valid_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DATA   = 3'd1;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd2;
`endif
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] BREAK  = 3'd4;

    logic [2:0]           state, state_next;
    logic [CNT_W-1:0]     bit_cnt, cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 dv_next;
    logic                 ferr_next;
    logic                 ovr_next;
    logic                 busy_next;
    logic                 good;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_next;
    logic                 perr_next;
`endif

    // Next-state and next-output logic; only strobes advance the frame.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        shift_next = shift_reg;
        data_next  = data_o;
        dv_next    = data_valid_o & ~data_ready_i;
        ferr_next  = 1'b0;
        ovr_next   = 1'b0;
        good       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad;
        perr_next    = 1'b0;
`endif
        if (bit_valid_i) begin
            case (state)
                IDLE: begin
                    if (!bit_i) begin
                        state_next = DATA;
                        cnt_next   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_next = 1'b0;
`endif
                    end
                end
                DATA: begin
                    shift_next = {bit_i, shift_reg[DATA_BITS-1:1]};
                    cnt_next   = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    par_bad_next = ^{bit_i, shift_reg};
                    state_next   = STOP;
                end
`endif
                STOP: begin
                    if (bit_i) begin
                        state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) perr_next = 1'b1;
                        else         good      = 1'b1;
`else
                        good = 1'b1;
`endif
                    end else begin
                        // A bad stop bit outranks a parity mismatch so only one error pulses.
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
                BREAK: begin
                    if (bit_i) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end

        // A completing frame replaces a byte being consumed this cycle, else overruns.
        if (good) begin
            if (data_valid_o && !data_ready_i) begin
                ovr_next = 1'b1;
            end else begin
                data_next = shift_reg;
                dv_next   = 1'b1;
            end
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= cnt_next;
            shift_reg    <= shift_next;
            data_o       <= data_next;
            data_valid_o <= dv_next;
            frame_err_o  <= ferr_next;
            overrun_o    <= ovr_next;
            busy_o       <= busy_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            par_bad      <= par_bad_next;
            parity_err_o <= perr_next;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed self-checking bench for uart_rx_framer (DATA_BITS=8).
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_framer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       bit_i;
    logic       bit_valid_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       data_ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;
    logic       busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0, multi_cnt = 0;
    int base;
    logic       mon_en = 1'b0;
    logic       snap_dv;
    logic [7:0] snap_data;

    uart_rx_framer #(.DATA_BITS(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse counters, sampled shortly after each rising edge.
    always @(posedge clk_i) begin
        #2;
        if (mon_en) begin
            if (frame_err_o)  ferr_cnt++;
            if (parity_err_o) perr_cnt++;
            if (overrun_o)    ovr_cnt++;
            if (int'(frame_err_o) + int'(parity_err_o) + int'(overrun_o) > 1) multi_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One strobe; outputs are snapshotted the cycle after it, then the line idles.
    task automatic strobe(input logic b, input logic rdy);
        @(negedge clk_i);
        bit_i        = b;
        bit_valid_i  = 1'b1;
        data_ready_i = rdy;
        @(negedge clk_i);
        bit_valid_i  = 1'b0;
        data_ready_i = 1'b0;
        snap_dv      = data_valid_o;
        snap_data    = data_o;
        repeat (15) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rdy_on_stop);
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) strobe(d[i], 1'b0);
`ifdef UART_RX_PARITY_EN
        strobe(^d, 1'b0);
`endif
        strobe(stop, rdy_on_stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic p);
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) strobe(d[i], 1'b0);
        strobe(p, 1'b0);
        strobe(1'b1, 1'b0);
    endtask
`endif

    task automatic consume();
        @(negedge clk_i);
        data_ready_i = 1'b1;
        @(negedge clk_i);
        data_ready_i = 1'b0;
        check("consume_dv", 32'(data_valid_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; bit_i = 1'b1; bit_valid_i = 1'b0; data_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_dv",   32'(data_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_errs", {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Start, data 0x4A LSB-first, stop 1.
        send_frame(8'h4A, 1'b1, 1'b0);
        check("a_snap_dv",   32'(snap_dv), 32'd1);
        check("a_snap_data", 32'(snap_data), 32'h4A);
        check("a_busy",      32'(busy_o), 32'd0);
        repeat (20) @(negedge clk_i);
        check("a_held_dv",   32'(data_valid_o), 32'd1);
        check("a_held_data", 32'(data_o), 32'h4A);
        consume();

        // Bad stop bit, held-low line, then release.
        base = ferr_cnt;
        send_frame(8'h33, 1'b0, 1'b0);
        check("b_ferr",    32'(ferr_cnt - base), 32'd1);
        check("b_dv",      32'(snap_dv), 32'd0);
        check("b_busy",    32'(busy_o), 32'd1);
        for (int i = 0; i < 12; i++) strobe(1'b0, 1'b0);
        check("b_hold_busy", 32'(busy_o), 32'd1);
        check("b_hold_ferr", 32'(ferr_cnt - base), 32'd1);
        check("b_hold_dv",   32'(data_valid_o), 32'd0);
        strobe(1'b1, 1'b0);
        check("b_idle_busy", 32'(busy_o), 32'd0);

        // Overrun: second frame dropped while the first is unconsumed.
        base = ovr_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        check("c_first_data", 32'(snap_data), 32'h55);
        send_frame(8'hA3, 1'b1, 1'b0);
        check("c_ovr",  32'(ovr_cnt - base), 32'd1);
        check("c_data", 32'(data_o), 32'h55);
        check("c_dv",   32'(data_valid_o), 32'd1);
        consume();

        // Consumer accepts on the very cycle the second frame completes.
        send_frame(8'h55, 1'b1, 1'b0);
        base = ovr_cnt;
        send_frame(8'hA3, 1'b1, 1'b1);
        check("d_dv",   32'(snap_dv), 32'd1);
        check("d_data", 32'(snap_data), 32'hA3);
        check("d_ovr",  32'(ovr_cnt - base), 32'd0);

        // Reset mid-frame discards both the partial frame and the pending byte.
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
        check("e_pre_busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("e_rst_data", 32'(data_o), 32'h0);
        check("e_rst_dv",   32'(data_valid_o), 32'd0);
        check("e_rst_busy", 32'(busy_o), 32'd0);
        check("e_rst_errs", {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);
        rst_i = 1'b0;
        send_frame(8'h0F, 1'b1, 1'b0);
        check("e_dv",   32'(snap_dv), 32'd1);
        check("e_data", 32'(snap_data), 32'h0F);
        consume();

`ifdef UART_RX_PARITY_EN
        base = perr_cnt;
        send_frame_par(8'h07, 1'b1);
        check("p_ok_dv",   32'(snap_dv), 32'd1);
        check("p_ok_data", 32'(snap_data), 32'h07);
        check("p_ok_perr", 32'(perr_cnt - base), 32'd0);
        consume();
        send_frame_par(8'h07, 1'b0);
        check("p_bad_perr", 32'(perr_cnt - base), 32'd1);
        check("p_bad_dv",   32'(snap_dv), 32'd0);
        check("p_bad_busy", 32'(busy_o), 32'd0);
`else
        check("noparity_perr", 32'(perr_cnt), 32'd0);
`endif

        check("err_onehot", 32'(multi_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
